net_output_stage: RTL and testbench

- Sits directly downstream of the network top level. Consumes each 4-channel output frame on its one-cycle valid pulse and re-quantises it: arithmetic right shift, then saturation to OUT_W bits.
- Buffers frames in a small FIFO and streams them one channel per beat over a valid/ready interface toward the DAC/host sink. Channels are sent 0..3, with last asserted on channel 3.
- Decouples the free-running network from a back-pressuring consumer and flags dropped frames.

---
 rtl/net_output_stage.sv | 114 +++++++++++
 tb/tb_net_output_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/net_output_stage.sv
// Output stage: re-quantises 4-channel network frames (shift + saturate), buffers
// them in a frame FIFO and streams one channel per beat over valid/ready.
module net_output_stage #(
   parameter int W     = 16,
   parameter int OUT_W = 12,
   parameter int SHIFT = 2,
   parameter int DEPTH = 4,
   localparam int LW   = $clog2(DEPTH) + 1,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0][W-1:0]       in_data,
   input  logic                    in_v,
   output logic signed [OUT_W-1:0] out_data,
   output logic [1:0]              out_chan,
   output logic                    out_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LW-1:0]           level,
   output logic                    overflow,
   input  logic                    clear_overflow,
   output logic [7:0]              drop_count
);

   localparam logic signed [W-1:0] C_MAX = W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [W-1:0] C_MIN = W'(-(2 ** (OUT_W - 1)));

   // Floor shift (arithmetic) followed by clamp into the signed OUT_W range.
   function automatic logic [OUT_W-1:0] sat_q(input logic [W-1:0] x);
      logic signed [W-1:0] t;
      // NOTE: blocking '=' inside functions/always_comb; '<=' only in always_ff.
      t = $signed(x) >>> SHIFT;
      if (t > C_MAX)      return C_MAX[OUT_W-1:0];
      else if (t < C_MIN) return C_MIN[OUT_W-1:0];
      else                return t[OUT_W-1:0];
   endfunction

   logic [3:0][OUT_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;
   logic [1:0]            r_chan;
   logic                  r_overflow;
   logic [7:0]            r_drop_count;

   logic [3:0][OUT_W-1:0] w_q;
   logic [3:0][OUT_W-1:0] w_head;
   logic                  w_valid;
   logic                  w_accept;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_q = '0;
      for (int i = 0; i < 4; i++) begin
         w_q[i] = sat_q(in_data[i]);
      end
   end

   assign w_valid  = (r_level != '0);
   assign w_accept = w_valid && out_ready;
   assign w_pop    = w_accept && (r_chan == 2'd3);
   // A full FIFO still takes a frame when its head leaves on the same edge.
   assign w_push   = in_v && ((r_level != LW'(DEPTH)) || w_pop);
   assign w_drop   = in_v && !w_push;
   assign w_head   = r_mem[r_rd_ptr];

   // NOTE: frame storage has no reset; out_data is gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_chan       <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_accept) r_chan <= r_chan + 2'd1;

         if (w_push && !w_pop)      r_level <= r_level + 1'b1;
         else if (w_pop && !w_push) r_level <= r_level - 1'b1;

         // A drop on the same edge as a clear wins and restarts the count at 1.
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow)             r_drop_count <= 8'd1;
            else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
         end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
         end
      end
   end

   assign out_valid  = w_valid;
   assign out_data   = w_valid ? $signed(w_head[r_chan]) : '0;
   assign out_chan   = r_chan;
   assign out_last   = (r_chan == 2'd3);
   assign level      = r_level;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule

// File: tb/tb_net_output_stage.sv
// Directed bench for net_output_stage: a behavioural FIFO model feeds a beat
// scoreboard; every beat, level and flag is compared at the falling edge.
module tb_net_output_stage;

   localparam int W     = 16;
   localparam int OUT_W = 12;
   localparam int SHIFT = 2;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [OUT_W-1:0] data;
      logic [1:0]       chan;
   } beat_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [3:0][W-1:0]       in_data = '0;
   logic                    in_v = 1'b0;
   logic signed [OUT_W-1:0] out_data;
   logic [1:0]              out_chan;
   logic                    out_last;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [LW-1:0]           level;
   logic                    overflow;
   logic                    clear_overflow = 1'b0;
   logic [7:0]              drop_count;

   int    n_checks = 0;
   int    n_errors = 0;
   beat_t sb[$];
   int    m_level = 0;
   int    m_chan  = 0;
   int    m_drops = 0;
   logic  m_ovf   = 1'b0;

   net_output_stage #(.W(W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_v(in_v),
      .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .overflow(overflow), .clear_overflow(clear_overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Integer reference: floor division by 2^SHIFT, then clamp.
   function automatic logic [OUT_W-1:0] quant(input logic [W-1:0] x);
      int v;
      int t;
      v = int'($signed(x));
      t = v >>> SHIFT;
      if (t > 2 ** (OUT_W - 1) - 1) t = 2 ** (OUT_W - 1) - 1;
      if (t < -(2 ** (OUT_W - 1)))  t = -(2 ** (OUT_W - 1));
      return t[OUT_W-1:0];
   endfunction

   // One clock: compare at negedge, advance the model, return just after posedge.
   task automatic step();
      logic acc;
      logic pop;
      logic push;
      logic drop;
      beat_t b;
      @(negedge clk);
      check("out_valid", {31'd0, out_valid}, {31'd0, m_level != 0});
      check("level", 32'(level), 32'(m_level));
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("drop_count", 32'(drop_count), 32'(m_drops));
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("beat_unexpected", 32'd1, 32'd0);
         end else begin
            b = sb[0];
            check("out_data", 32'(out_data[OUT_W-1:0]), 32'(b.data));
            check("out_chan", 32'(out_chan), 32'(b.chan));
            check("out_last", {31'd0, out_last}, {31'd0, b.chan == 2'd3});
            if (out_ready) void'(sb.pop_front());
         end
      end
      if (!rst) begin
         m_level = 0; m_chan = 0; m_drops = 0; m_ovf = 1'b0;
         sb.delete();
      end else begin
         acc  = (m_level != 0) && out_ready;
         pop  = acc && (m_chan == 3);
         push = in_v && ((m_level < DEPTH) || pop);
         drop = in_v && !push;
         if (push) begin
            for (int i = 0; i < 4; i++) begin
               b.data = quant(in_data[i]);
               b.chan = 2'(i);
               sb.push_back(b);
            end
         end
         if (acc) m_chan = (m_chan + 1) % 4;
         m_level = m_level + (push ? 1 : 0) - (pop ? 1 : 0);
         if (drop) begin
            m_ovf   = 1'b1;
            m_drops = clear_overflow ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
         end else if (clear_overflow) begin
            m_ovf   = 1'b0;
            m_drops = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
      in_data[0] = a; in_data[1] = b; in_data[2] = c; in_data[3] = d;
      in_v = 1'b1;
      step();
      in_v = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b0;
      steps(2);
      rst = 1'b1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", 32'(out_data[OUT_W-1:0]), 32'd0);
      check("rst_chan", 32'(out_chan), 32'd0);
      check("rst_last", {31'd0, out_last}, 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_drops", 32'(drop_count), 32'd0);
      steps(2);

      // Saturation / rounding with one-edge latency
      out_ready = 1'b1;
      send(16'h7FFF, 16'h8000, 16'd100, 16'hFFFB);
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_chan", 32'(out_chan), 32'd0);
      check("sat_pos", 32'(out_data[OUT_W-1:0]), 32'(12'd2047));
      steps(4);
      check("sat_drained", 32'(level), 32'd0);

      // Back-pressure: hold channel 0 for 5 cycles
      out_ready = 1'b0;
      send(16'd4, 16'd8, 16'd12, 16'd16);
      steps(5);
      check("bp_hold", 32'(out_data[OUT_W-1:0]), 32'd1);
      out_ready = 1'b1;
      steps(5);

      // Overflow: 6 frames into a 4-deep FIFO
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         send(16'(k * 40), 16'(k * 40 + 4), 16'(k * 40 + 8), 16'(k * 40 + 12));
         step();
      end
      check("ovf_level", 32'(level), 32'd4);
      check("ovf_flag", {31'd0, overflow}, 32'd1);
      check("ovf_drops", 32'(drop_count), 32'd2);
      out_ready = 1'b1;
      steps(16);
      check("ovf_drained", 32'(level), 32'd0);
      check("ovf_sb_empty", 32'(sb.size()), 32'd0);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      check("clr_flag", {31'd0, overflow}, 32'd0);
      check("clr_drops", 32'(drop_count), 32'd0);

      // Full FIFO with push on the channel-3 pop edge
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(16'(k * 4 + 400), 16'(k), 16'hFFF0, 16'(k * 8));
      out_ready = 1'b1;
      steps(3);
      send(16'd1000, 16'd2000, 16'd3000, 16'd4000);
      check("fullpop_level", 32'(level), 32'd4);
      check("fullpop_ovf", {31'd0, overflow}, 32'd0);

      // Drop and clear on the same edge: drop wins
      out_ready = 1'b0;
      clear_overflow = 1'b1;
      send(16'd7, 16'd7, 16'd7, 16'd7);
      clear_overflow = 1'b0;
      check("dropclr_flag", {31'd0, overflow}, 32'd1);
      check("dropclr_drops", 32'(drop_count), 32'd1);

      // drop_count saturates at 255
      for (int k = 0; k < 260; k++) send(16'd9, 16'd9, 16'd9, 16'd9);
      check("drops_sat", 32'(drop_count), 32'd255);
      out_ready = 1'b1;
      steps(16);
      check("sat_drained2", 32'(level), 32'd0);

      // Reset mid-frame, then a fresh frame from channel 0
      send(16'd20, 16'd24, 16'd28, 16'd32);
      steps(2);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_level", 32'(level), 32'd0);
      send(16'hFFFF, 16'd3, 16'd4, 16'hFFF8);
      check("mid_rst_chan", 32'(out_chan), 32'd0);
      steps(5);
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
